// File: rtl/bsg_link_reset_sequencer_pkg.sv
// Shared types and defaults for the bsg_link reset bring-up sequencer.
package bsg_link_reset_sequencer_pkg;

   localparam int unsigned link_rst_seq_state_width_gp = 3;
   localparam int unsigned link_rst_seq_default_hold_gp = 16;

   typedef enum logic [link_rst_seq_state_width_gp-1:0] {
      LRS_IDLE,
      LRS_TOKEN_PRE,
      LRS_TOKEN_HI,
      LRS_TOKEN_POST,
      LRS_UP_REL,
      LRS_DOWN_REL,
      LRS_CORE_REL,
      LRS_DONE
   } link_rst_seq_state_e;

   // Phase that follows a timed phase once its hold expires.
   function automatic link_rst_seq_state_e link_rst_seq_next_phase(input link_rst_seq_state_e s);
      case (s)
         LRS_TOKEN_PRE:  return LRS_TOKEN_HI;
         LRS_TOKEN_HI:   return LRS_TOKEN_POST;
         LRS_TOKEN_POST: return LRS_UP_REL;
         LRS_UP_REL:     return LRS_DOWN_REL;
         LRS_DOWN_REL:   return LRS_CORE_REL;
         LRS_CORE_REL:   return LRS_DONE;
         default:        return LRS_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/bsg_link_reset_sequencer_timer.sv
// Loadable down counter shared by every timed phase of the sequencer.
module bsg_link_reset_sequencer_timer #(
   parameter int unsigned width_p = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [width_p-1:0] load_val,
   output logic               zero
);

   logic [width_p-1:0] count;

   // Load on phase entry, otherwise count down and rest at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - width_p'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/bsg_link_reset_sequencer.sv
// Timed reset bring-up for a group of bsg_link DDR channels:
// token pulse, upstream IO release, downstream IO release, core release.
module bsg_link_reset_sequencer
   import bsg_link_reset_sequencer_pkg::*;
#(
   parameter int unsigned num_links_p    = 2,
   parameter int unsigned hold_width_p   = 8,
   parameter int unsigned default_hold_p = link_rst_seq_default_hold_gp
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [num_links_p-1:0]  link_en_i,
   input  logic [hold_width_p-1:0] hold_cycles_i,
   input  logic                    abort_i,
   output logic [num_links_p-1:0]  token_reset_o,
   output logic [num_links_p-1:0]  up_io_reset_o,
   output logic [num_links_p-1:0]  down_io_reset_o,
   output logic [num_links_p-1:0]  core_reset_o,
   output logic                    busy_o,
   output logic                    done_o
);

   // Default hold must be a non-zero value representable by the counter.
   if (default_hold_p == 0 || default_hold_p >= (1 << hold_width_p)) begin : g_bad_default_hold
      $error("default_hold_p must be in 1..2**hold_width_p-1");
   end

   localparam logic [hold_width_p-1:0] default_hold_lp = hold_width_p'(default_hold_p);

   link_rst_seq_state_e     state_r, state_n;
   logic [num_links_p-1:0]  en_r, en_n;
   logic [hold_width_p-1:0] hold_r, hold_n, start_hold, load_val;
   logic                    load, zero;

   logic [num_links_p-1:0]  token_n, up_n, down_n, core_n;
   logic                    busy_n, done_n;

   // Zero on the hold input selects the built-in default hold.
   assign start_hold = (hold_cycles_i == '0) ? default_hold_lp : hold_cycles_i;

   bsg_link_reset_sequencer_timer #(
      .width_p (hold_width_p)
   ) timer (
      .clk      (clk_i),
      .reset    (reset_i),
      .load     (load),
      .load_val (load_val),
      .zero     (zero)
   );

   // Next state, capture, timer load and decode of the next registered outputs.
   always_comb begin
      state_n  = state_r;
      en_n     = en_r;
      hold_n   = hold_r;
      load     = 1'b0;
      load_val = hold_r - hold_width_p'(1);

      token_n  = '0;
      up_n     = '1;
      down_n   = '1;
      core_n   = '1;
      busy_n   = 1'b0;
      done_n   = 1'b0;

      if (abort_i) begin
         state_n = LRS_IDLE;
      end else begin
         case (state_r)
            LRS_IDLE, LRS_DONE: begin
               if (start_i) begin
                  state_n  = LRS_TOKEN_PRE;
                  en_n     = link_en_i;
                  hold_n   = start_hold;
                  load     = 1'b1;
                  load_val = start_hold - hold_width_p'(1);
               end
            end
            default: begin
               if (zero) begin
                  state_n = link_rst_seq_next_phase(state_r);
                  load    = 1'b1;
               end
            end
         endcase
      end

      // Releases accumulate phase by phase and only touch enabled links.
      case (state_n)
         LRS_TOKEN_PRE, LRS_TOKEN_POST: begin
            busy_n = 1'b1;
         end
         LRS_TOKEN_HI: begin
            busy_n  = 1'b1;
            token_n = en_n;
         end
         LRS_UP_REL: begin
            busy_n = 1'b1;
            up_n   = ~en_n;
         end
         LRS_DOWN_REL: begin
            busy_n = 1'b1;
            up_n   = ~en_n;
            down_n = ~en_n;
         end
         LRS_CORE_REL: begin
            busy_n = 1'b1;
            up_n   = ~en_n;
            down_n = ~en_n;
            core_n = ~en_n;
         end
         LRS_DONE: begin
            done_n = 1'b1;
            up_n   = ~en_n;
            down_n = ~en_n;
            core_n = ~en_n;
         end
         default: ;
      endcase
   end

   // State, captured configuration and registered outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r         <= LRS_IDLE;
         en_r            <= '0;
         hold_r          <= default_hold_lp;
         token_reset_o   <= '0;
         up_io_reset_o   <= '1;
         down_io_reset_o <= '1;
         core_reset_o    <= '1;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
      end else begin
         state_r         <= state_n;
         en_r            <= en_n;
         hold_r          <= hold_n;
         token_reset_o   <= token_n;
         up_io_reset_o   <= up_n;
         down_io_reset_o <= down_n;
         core_reset_o    <= core_n;
         busy_o          <= busy_n;
         done_o          <= done_n;
      end
   end

endmodule

// File: tb/tb_bsg_link_reset_sequencer.sv
// Scoreboard bench for bsg_link_reset_sequencer: a cycle-count reference model
// pushes the expected outputs for every driven cycle and they are compared after the edge.
module tb_bsg_link_reset_sequencer;

   localparam int unsigned nl = 2;
   localparam int unsigned hw = 8;
   localparam int unsigned dh = 16;

   logic          clk = 1'b0;
   logic          reset, start, abort;
   logic [nl-1:0] link_en;
   logic [hw-1:0] hold_cycles;
   logic [nl-1:0] token_reset, up_io_reset, down_io_reset, core_reset;
   logic          busy, done;

   always #5 clk = ~clk;

   bsg_link_reset_sequencer #(
      .num_links_p    (nl),
      .hold_width_p   (hw),
      .default_hold_p (dh)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .start_i         (start),
      .link_en_i       (link_en),
      .hold_cycles_i   (hold_cycles),
      .abort_i         (abort),
      .token_reset_o   (token_reset),
      .up_io_reset_o   (up_io_reset),
      .down_io_reset_o (down_io_reset),
      .core_reset_o    (core_reset),
      .busy_o          (busy),
      .done_o          (done)
   );

   int checks = 0;
   int passed = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
   endtask

   // Reference model: cycles elapsed since accepted start, phase = (t-1)/H.
   bit        m_active = 1'b0;
   bit        m_done   = 1'b0;
   int        m_t      = 0;
   int        m_h      = dh;
   logic [1:0] m_en    = '0;

   logic [9:0] exp_q[$];

   function automatic logic [9:0] model_out();
      logic [1:0] tok, up, dn, co;
      logic       b, d;
      int         ph;
      tok = 2'b00; up = 2'b11; dn = 2'b11; co = 2'b11; b = 1'b0; d = 1'b0;
      if (m_active) begin
         ph = (m_t - 1) / m_h;
         b  = 1'b1;
         if (ph == 1) tok = m_en;
         if (ph >= 3) up  = ~m_en;
         if (ph >= 4) dn  = ~m_en;
         if (ph >= 5) co  = ~m_en;
      end else if (m_done) begin
         up = ~m_en; dn = ~m_en; co = ~m_en; d = 1'b1;
      end
      return {tok, up, dn, co, b, d};
   endfunction

   task automatic model_step();
      if (reset) begin
         m_active = 1'b0; m_done = 1'b0; m_en = '0;
      end else if (abort) begin
         m_active = 1'b0; m_done = 1'b0;
      end else if (!m_active && start) begin
         m_active = 1'b1; m_done = 1'b0; m_t = 1; m_en = link_en;
         m_h = (hold_cycles == '0) ? dh : int'(hold_cycles);
      end else if (m_active) begin
         m_t++;
         if (m_t > 6 * m_h) begin
            m_active = 1'b0; m_done = 1'b1;
         end
      end
   endtask

   // One clock: inputs already driven, push expectation, compare after the edge.
   task automatic step(input string tag);
      logic [9:0] want, got;
      logic [1:0] viol;
      model_step();
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      got  = {token_reset, up_io_reset, down_io_reset, core_reset, busy, done};
      check_eq(tag, 32'(got), 32'(want));
      viol = (~core_reset & down_io_reset) | (~down_io_reset & up_io_reset);
      check_eq({tag, "_mono"}, 32'(viol), 32'd0);
   endtask

   // Issue a start and count cycles until done_o, bounded by budget.
   task automatic run_until_done(input string tag, input int want, input int budget);
      int n;
      n = 0;
      start = 1'b1;
      for (int i = 0; i < budget; i++) begin
         step(tag);
         start = 1'b0;
         n++;
         if (done) break;
      end
      check_eq({tag, "_latency"}, 32'(n), 32'(want));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; link_en = '0; hold_cycles = '0;
      repeat (3) step("reset");
      reset = 1'b0;
      step("idle");

      // Full sequence, both links, H=4: done at cycle 25.
      link_en = 2'b11; hold_cycles = 8'd4;
      run_until_done("h4", 25, 40);
      repeat (3) step("h4_done");

      // Default hold via zero, restarted from DONE: done at cycle 97.
      hold_cycles = 8'd0;
      run_until_done("hdef", 97, 120);
      step("hdef_done");

      // Only link 0 enabled; link 1 stays in reset.
      link_en = 2'b01; hold_cycles = 8'd3;
      run_until_done("en01", 19, 30);
      step("en01_done");

      // Abort while in DOWN_REL (cycles 17..20 for H=4), then rerun.
      abort = 1'b1; step("abort_idle"); abort = 1'b0;
      link_en = 2'b11; hold_cycles = 8'd4;
      start = 1'b1; step("abort_run"); start = 1'b0;
      repeat (17) step("abort_run");
      check_eq("abort_in_down", 32'({up_io_reset, down_io_reset, core_reset}), 32'(6'b000011));
      abort = 1'b1; step("abort_hit"); abort = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      repeat (2) step("abort_after");
      hold_cycles = 8'd2;
      run_until_done("abort_rerun", 13, 20);

      // Abort and start together: abort wins.
      abort = 1'b1; start = 1'b1; step("abort_vs_start");
      abort = 1'b0; start = 1'b0; step("abort_vs_start");

      // Start held high: no mid-sequence restart; DONE restarts with new mask.
      link_en = 2'b11; hold_cycles = 8'd2; start = 1'b1;
      step("held");
      link_en = 2'b10;
      repeat (30) step("held");
      start = 1'b0;
      repeat (15) step("held_tail");

      // Random start/abort/hold/reset.
      for (int c = 0; c < 10000; c++) begin
         reset       = ($urandom_range(0, 499) == 0);
         abort       = ($urandom_range(0, 149) == 0);
         start       = ($urandom_range(0, 19) == 0);
         link_en     = 2'($urandom_range(0, 3));
         hold_cycles = 8'($urandom_range(0, 6));
         step("rand");
      end
      reset = 1'b0; abort = 1'b0; start = 1'b0;
      step("drain");
      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
